// File: rtl/sponge_pkg.sv
// Shared constants and FSM state type for the sponge sequencer.
package sponge_pkg;

    localparam int RATE_WIDTH     = 32;
    localparam int REMAINWIDTH    = 20;
    localparam int ROUND_W        = 4;
    localparam int ROUNDS_A       = 12;
    localparam int ROUNDS_B       = 6;

    // Watchdog limit for a permutation, as a multiple of the long round count.
    localparam int TIMEOUT_MULT   = 4;
    localparam int TIMEOUT_CYCLES = TIMEOUT_MULT * ROUNDS_A;
    localparam int WD_W           = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_I,
        S_ABSORB,
        S_XOR,
        S_PERM_B,
        S_WAIT_B,
        S_FINAL,
        S_WAIT_F,
        S_SQUEEZE,
        S_SQ_PERM,
        S_SQ_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/sponge_ctrl_if.sv
// Bundle of message, permutation and squeeze signals around the sponge sequencer.
// Optional err output exists only when SPONGE_PERM_TIMEOUT_EN is defined.
interface sponge_ctrl_if;
    import sponge_pkg::*;

    logic                   start;
    logic [REMAINWIDTH-1:0] out_len;
    logic                   msg_valid;
    logic [RATE_WIDTH-1:0]  msg_data;
    logic                   msg_last;
    logic                   msg_ready;
    logic                   init_load;
    logic                   rate_xor;
    logic [RATE_WIDTH-1:0]  rate_data;
    logic                   perm_start;
    logic [ROUND_W-1:0]     perm_rounds;
    logic                   perm_done;
    logic [RATE_WIDTH-1:0]  state_rate;
    logic                   sq_valid;
    logic [RATE_WIDTH-1:0]  sq_data;
    logic                   sq_last;
    logic                   sq_ready;
    logic                   busy;
    logic                   done;
`ifdef SPONGE_PERM_TIMEOUT_EN
    logic                   err;
`endif

    // Controller view.
    modport master (
`ifdef SPONGE_PERM_TIMEOUT_EN
        output err,
`endif
        input  start, out_len, msg_valid, msg_data, msg_last,
        input  perm_done, state_rate, sq_ready,
        output msg_ready, init_load, rate_xor, rate_data,
        output perm_start, perm_rounds,
        output sq_valid, sq_data, sq_last, busy, done
    );

    // Requester / datapath / consumer view.
    modport slave (
`ifdef SPONGE_PERM_TIMEOUT_EN
        input  err,
`endif
        output start, out_len, msg_valid, msg_data, msg_last,
        output perm_done, state_rate, sq_ready,
        input  msg_ready, init_load, rate_xor, rate_data,
        input  perm_start, perm_rounds,
        input  sq_valid, sq_data, sq_last, busy, done
    );

endinterface

// File: rtl/sponge_len_counter.sv
// Remaining-output-length counter: load, saturating decrement by one rate word.
module sponge_len_counter
    import sponge_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [REMAINWIDTH-1:0] load_val,
    input  logic                   dec,
    output logic [REMAINWIDTH-1:0] remaining,
    output logic                   is_last,
    output logic                   is_zero
);

    localparam logic [REMAINWIDTH-1:0] STEP = REMAINWIDTH'(RATE_WIDTH);

    // Load on new hash, otherwise subtract one word and clamp at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_val;
        end else if (dec) begin
            remaining <= (remaining > STEP) ? remaining - STEP : '0;
        end
    end

    assign is_last = (remaining <= STEP);
    assign is_zero = (remaining == '0);

endmodule

// File: rtl/sponge_ctrl.sv
// Sponge sequencer: IV load, absorb, permutation scheduling and squeeze.
// All handshake/strobe outputs are registered from the next-state decode.
// Optional watchdog: SPONGE_PERM_TIMEOUT_EN.
module sponge_ctrl
    import sponge_pkg::*;
(
    input logic           clk,
    input logic           reset_n,
    sponge_ctrl_if.master bus
);

    state_t                 state;
    state_t                 state_next;
    logic                   perm_issue;
    logic [ROUND_W-1:0]     rounds_sel;
    logic                   msg_fire;
    logic                   sq_fire;
    logic                   len_load;
    logic                   last_q;
    logic [REMAINWIDTH-1:0] remaining;
    logic                   rem_last;
    logic                   rem_zero;
    logic                   timeout;

    assign msg_fire = (state == S_ABSORB) && bus.msg_valid && bus.msg_ready;
    assign sq_fire  = (state == S_SQUEEZE) && bus.sq_valid && bus.sq_ready;
    assign len_load = (state == S_IDLE) && bus.start;

    sponge_len_counter u_len (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (len_load),
        .load_val (bus.out_len),
        .dec      (sq_fire),
        .remaining(remaining),
        .is_last  (rem_last),
        .is_zero  (rem_zero)
    );

`ifdef SPONGE_PERM_TIMEOUT_EN
    logic [WD_W-1:0] wd_cnt;
    logic            in_wait;

    assign in_wait = (state == S_WAIT_I) || (state == S_WAIT_B) ||
                     (state == S_WAIT_F) || (state == S_SQ_WAIT);
    assign timeout = in_wait && !bus.perm_done && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Count cycles spent waiting for the current permutation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (!in_wait || bus.perm_done) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Sticky error flag, cleared by the next accepted start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.err <= 1'b0;
        end else if (len_load) begin
            bus.err <= 1'b0;
        end else if (timeout) begin
            bus.err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and permutation request selection.
    always_comb begin
        state_next = state;
        perm_issue = 1'b0;
        rounds_sel = bus.perm_rounds;
        case (state)
            S_IDLE:    if (bus.start) state_next = S_INIT;
            S_INIT: begin
                state_next = S_WAIT_I;
                perm_issue = 1'b1;
                rounds_sel = ROUND_W'(ROUNDS_A);
            end
            S_WAIT_I:  if (bus.perm_done) state_next = S_ABSORB;
            S_ABSORB:  if (msg_fire) state_next = S_XOR;
            S_XOR:     state_next = last_q ? S_FINAL : S_PERM_B;
            S_PERM_B: begin
                state_next = S_WAIT_B;
                perm_issue = 1'b1;
                rounds_sel = ROUND_W'(ROUNDS_B);
            end
            S_WAIT_B:  if (bus.perm_done) state_next = S_ABSORB;
            S_FINAL: begin
                state_next = S_WAIT_F;
                perm_issue = 1'b1;
                rounds_sel = ROUND_W'(ROUNDS_A);
            end
            S_WAIT_F:  if (bus.perm_done) state_next = rem_zero ? S_DONE : S_SQUEEZE;
            S_SQUEEZE: if (sq_fire) state_next = bus.sq_last ? S_DONE : S_SQ_PERM;
            S_SQ_PERM: begin
                state_next = S_SQ_WAIT;
                perm_issue = 1'b1;
                rounds_sel = ROUND_W'(ROUNDS_B);
            end
            S_SQ_WAIT: if (bus.perm_done) state_next = S_SQUEEZE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        if (timeout) state_next = S_IDLE;
    end

    // Registered outputs: strobes follow the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.msg_ready   <= 1'b0;
            bus.init_load   <= 1'b0;
            bus.rate_xor    <= 1'b0;
            bus.rate_data   <= '0;
            bus.perm_start  <= 1'b0;
            bus.perm_rounds <= '0;
            bus.sq_valid    <= 1'b0;
            bus.sq_data     <= '0;
            bus.sq_last     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            last_q          <= 1'b0;
        end else begin
            bus.msg_ready  <= (state_next == S_ABSORB);
            bus.init_load  <= len_load;
            bus.rate_xor   <= (state_next == S_XOR);
            bus.perm_start <= perm_issue;
            bus.sq_valid   <= (state_next == S_SQUEEZE);
            bus.busy       <= (state_next != S_IDLE);
            bus.done       <= (state_next == S_DONE);
            if (perm_issue) begin
                bus.perm_rounds <= rounds_sel;
            end
            if (msg_fire) begin
                bus.rate_data <= bus.msg_data;
                last_q        <= bus.msg_last;
            end
            // Capture the rate once on entry so the word stays stable under backpressure.
            if ((state_next == S_SQUEEZE) && (state != S_SQUEEZE)) begin
                bus.sq_data <= bus.state_rate;
                bus.sq_last <= rem_last;
            end else if (state_next != S_SQUEEZE) begin
                bus.sq_last <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sponge_ctrl.sv
// Self-checking bench for sponge_ctrl with behavioural permutation core,
// consumer and requester models.
module tb_sponge_ctrl;
    import sponge_pkg::*;

    logic clk;
    logic reset_n;

    sponge_ctrl_if bus ();

    sponge_ctrl dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // observation state
    int          perm_q[$];
    int          ps_t[$];
    logic [31:0] xor_q[$];
    logic [31:0] sq_got_q[$];
    logic [31:0] sq_exp_q[$];
    bit          sq_last_q[$];
    int          lat_obs[$];
    int          lat_exp[$];
    int          n_init, n_done, unstable;
    int          t_start, t_done, t_pd, t_xor;
    bit          xor_pend, sq_hold, prev_ready;
    logic [31:0] held;

    // model controls
    logic [31:0] last_rate;
    bit          hold_done;
    bit          stray_req;
    int          stall_left;
    logic [31:0] msg_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        perm_q.delete(); ps_t.delete(); xor_q.delete();
        sq_got_q.delete(); sq_exp_q.delete(); sq_last_q.delete();
        lat_obs.delete(); lat_exp.delete();
        n_init = 0; n_done = 0; unstable = 0;
        t_start = 0; t_done = 0; t_pd = 0; t_xor = 0;
        xor_pend = 0; sq_hold = 0;
    endtask

    // Permutation core: done pulse 1..5 cycles after start, fresh rate with it.
    task automatic perm_model();
        int cd = 0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n) begin
                cd = 0;
                bus.perm_done = 1'b0;
            end else begin
                bus.perm_done  = 1'b0;
                bus.state_rate = $urandom();
                if (stray_req) begin
                    stray_req     = 1'b0;
                    bus.perm_done = 1'b1;
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0 && !hold_done) begin
                        last_rate      = $urandom();
                        bus.state_rate = last_rate;
                        bus.perm_done  = 1'b1;
                    end
                end
                if (bus.perm_start) cd = $urandom_range(1, 5);
            end
        end
    endtask

    // Output consumer: forced stall on request, otherwise random ready.
    task automatic consumer();
        forever begin
            @(posedge clk); #1;
            if (bus.sq_valid && stall_left > 0) begin
                bus.sq_ready = 1'b0;
                stall_left--;
            end else begin
                bus.sq_ready = ($urandom_range(0, 3) != 0);
            end
        end
    endtask

    // Passive observer; samples on the falling edge what the next rising edge will use.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.start && !bus.busy) t_start = cyc;
                if (bus.init_load) n_init++;
                if (bus.perm_start) begin
                    perm_q.push_back(int'(bus.perm_rounds));
                    ps_t.push_back(cyc);
                end
                if (bus.perm_done) t_pd = cyc;
                if (bus.rate_xor) begin
                    xor_q.push_back(bus.rate_data);
                    t_xor    = cyc;
                    xor_pend = 1'b1;
                end
                if (bus.msg_ready && !prev_ready && xor_pend && ps_t.size() > 0) begin
                    lat_obs.push_back(cyc - t_xor);
                    lat_exp.push_back(t_pd - ps_t[ps_t.size()-1] + 3);
                    xor_pend = 1'b0;
                end
                prev_ready = bus.msg_ready;
                if (bus.sq_valid) begin
                    if (!sq_hold) begin
                        sq_hold = 1'b1;
                        held    = bus.sq_data;
                        sq_got_q.push_back(bus.sq_data);
                        sq_exp_q.push_back(last_rate);
                        sq_last_q.push_back(bus.sq_last);
                    end else if (bus.sq_data !== held) begin
                        unstable++;
                    end
                    if (bus.sq_ready) sq_hold = 1'b0;
                end else begin
                    sq_hold = 1'b0;
                end
                if (bus.done) begin
                    n_done++;
                    t_done = cyc;
                end
            end
        end
    endtask

    task automatic pulse_start(input int len);
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.out_len = REMAINWIDTH'(len);
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.out_len = REMAINWIDTH'($urandom());
    endtask

    // Full hash of msg_q with len output bits, compared against the sponge rules.
    task automatic run_hash(input int len, input int stall);
        int tmo;
        int guard;
        int nw;
        int exp_perm[$];
        clear_obs();
        tmo        = 0;
        stall_left = stall;
        pulse_start(len);
        for (int i = 0; i < msg_q.size(); i++) begin
            bus.msg_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            bus.msg_valid = 1'b1;
            bus.msg_data  = msg_q[i];
            bus.msg_last  = (i == msg_q.size() - 1);
            guard = 0;
            while (!bus.msg_ready && guard < 500) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 500) tmo++;
            @(posedge clk); #1;
            bus.msg_valid = 1'b0;
            bus.msg_last  = 1'b0;
        end
        guard = 0;
        while (n_done == 0 && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 3000) tmo++;
        repeat (3) begin @(posedge clk); #1; end

        nw = (len + RATE_WIDTH - 1) / RATE_WIDTH;
        exp_perm.push_back(ROUNDS_A);
        for (int i = 1; i < msg_q.size(); i++) exp_perm.push_back(ROUNDS_B);
        exp_perm.push_back(ROUNDS_A);
        for (int i = 1; i < nw; i++) exp_perm.push_back(ROUNDS_B);

        check("no_timeout", 64'(tmo), 64'(0));
        check("init_load_cnt", 64'(n_init), 64'(1));
        check("perm_cnt", 64'(perm_q.size()), 64'(exp_perm.size()));
        for (int i = 0; i < exp_perm.size() && i < perm_q.size(); i++)
            check("perm_rounds", 64'(perm_q[i]), 64'(exp_perm[i]));
        check("xor_cnt", 64'(xor_q.size()), 64'(msg_q.size()));
        for (int i = 0; i < msg_q.size() && i < xor_q.size(); i++)
            check("rate_data", 64'(xor_q[i]), 64'(msg_q[i]));
        check("sq_cnt", 64'(sq_got_q.size()), 64'(nw));
        for (int i = 0; i < sq_got_q.size(); i++) begin
            check("sq_data", 64'(sq_got_q[i]), 64'(sq_exp_q[i]));
            check("sq_last", 64'(sq_last_q[i]), 64'(i == nw - 1));
        end
        check("sq_stable", 64'(unstable), 64'(0));
        check("done_cnt", 64'(n_done), 64'(1));
        check("remaining", 64'(dut.u_len.remaining), 64'(0));
        check("busy_after", 64'(bus.busy), 64'(0));
        if (ps_t.size() > 0) check("start_lat", 64'(ps_t[0] - t_start), 64'(2));
        for (int i = 0; i < lat_obs.size(); i++)
            check("absorb_lat", 64'(lat_obs[i]), 64'(lat_exp[i]));
        if (len == 0) check("done_lat", 64'(t_done - t_pd), 64'(1));
    endtask

    initial begin
        fork
            perm_model();
            consumer();
            monitor();
        join_none
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int guard;
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.out_len    = '0;
        bus.msg_valid  = 1'b0;
        bus.msg_data   = '0;
        bus.msg_last   = 1'b0;
        bus.perm_done  = 1'b0;
        bus.state_rate = '0;
        bus.sq_ready   = 1'b0;
        hold_done      = 1'b0;
        stray_req      = 1'b0;
        stall_left     = 0;
        last_rate      = '0;
        prev_ready     = 1'b0;
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", 64'({bus.busy, bus.done, bus.msg_ready, bus.init_load,
                               bus.rate_xor, bus.perm_start, bus.sq_valid, bus.sq_last}), 64'(0));
        check("rst_rounds", 64'(bus.perm_rounds), 64'(0));
        check("rst_data", {bus.rate_data, bus.sq_data}, 64'(0));
        check("rst_remaining", 64'(dut.u_len.remaining), 64'(0));
        @(posedge clk); #2;
        reset_n = 1'b1;

        // one pre-padded word, two output words
        msg_q = '{32'h7965_7370};
        run_hash(64, 0);
        // three words, single output word
        msg_q = '{$urandom(), $urandom(), $urandom()};
        run_hash(32, 0);
        // no output requested
        msg_q = '{$urandom(), $urandom()};
        run_hash(0, 0);
        // partial final word under backpressure
        msg_q = '{$urandom()};
        run_hash(40, 5);

        // random mix
        for (int k = 0; k < 6; k++) begin
            msg_q.delete();
            repeat ($urandom_range(1, 4)) msg_q.push_back($urandom());
            run_hash($urandom_range(0, 160), $urandom_range(0, 3));
        end

        // asynchronous reset while waiting on an intermediate permutation
        clear_obs();
        pulse_start(32);
        guard = 0;
        while (!bus.msg_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        bus.msg_valid = 1'b1;
        bus.msg_data  = $urandom();
        bus.msg_last  = 1'b0;
        @(posedge clk); #1;
        bus.msg_valid = 1'b0;
        hold_done     = 1'b1;
        while (!bus.perm_start && guard < 200) begin @(posedge clk); #1; guard++; end
        check("wb_wait_bound", 64'(guard >= 200), 64'(0));
        check("wb_rounds", 64'(bus.perm_rounds), 64'(ROUNDS_B));
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("wb_rst_ctrl", 64'({bus.busy, bus.done, bus.msg_ready, bus.init_load,
                                  bus.rate_xor, bus.perm_start, bus.sq_valid, bus.sq_last}), 64'(0));
        check("wb_rst_rounds", 64'(bus.perm_rounds), 64'(0));
        check("wb_rst_data", {bus.rate_data, bus.sq_data}, 64'(0));
        check("wb_rst_remaining", 64'(dut.u_len.remaining), 64'(0));
        repeat (2) @(posedge clk);
        #2;
        reset_n   = 1'b1;
        hold_done = 1'b0;
        @(posedge clk); #1;
        stray_req = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("stray_ignored", 64'({bus.busy, bus.perm_start, bus.msg_ready,
                                    bus.init_load, bus.done}), 64'(0));
        msg_q = '{$urandom(), $urandom()};
        run_hash(96, 0);

`ifdef SPONGE_PERM_TIMEOUT_EN
        // permutation never completes: watchdog returns to idle with err
        hold_done = 1'b1;
        pulse_start(64);
        guard = 0;
        while (bus.busy && guard < 200) begin @(posedge clk); #1; guard++; end
        check("tmo_bound", 64'(guard >= 200), 64'(0));
        check("tmo_err", 64'(bus.err), 64'(1));
        check("tmo_idle", 64'(bus.busy), 64'(0));
        hold_done = 1'b0;
        msg_q = '{$urandom()};
        run_hash(32, 0);
        check("err_cleared", 64'(bus.err), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
